// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I ALU decoder: ALU control codes,
// controller operation classes and the funct3 values it decodes.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int ALU_OP_W   = 2;

    // ALU control codes driven to the datapath ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

    // Operation classes issued by the main control FSM
    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALUOP_RSVD  = 2'b11;

    // funct3 field values (instruction bits [14:12])
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational next-value decode of {alu_control, illegal} from the
// controller's operation class and the instruction function fields.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [2:0]            funct3,
    input  logic                  op_5,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal
);

    // Fields not selected by alu_op are never read in that branch, so an
    // unknown value on them cannot reach the outputs.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi carries an immediate bit at [30]; only R-type subtracts
                    F3_ADD:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_control = ALU_SLT;
                    // no unsigned compare in the ALU: fall back to SLT and flag it
                    F3_SLTU: begin
                        alu_control = ALU_SLT;
                        illegal     = 1'b1;
                    end
                    F3_XOR:  alu_control = ALU_XOR;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
                    F3_SLL: begin
                        alu_control = ALU_SLL;
                        illegal     = funct7_5;
                    end
                    // SRA is unsupported: logical shift with illegal raised
                    F3_SR: begin
                        alu_control = ALU_SRL;
                        illegal     = funct7_5;
                    end
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            ALUOP_RSVD: begin
                alu_control = ALU_ADD;
                illegal     = 1'b1;
            end
            default: begin
                alu_control = ALU_ADD;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_alu_decoder.sv
// ALU control decoder for the multi-cycle RV32I core. Output is registered
// so the ALU code changes only on datapath state boundaries.
module riscv_alu_decoder
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [2:0]            funct3,
    input  logic                  op_5,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal
);

    logic [ALU_CTRL_W-1:0] alu_control_next;
    logic                  illegal_next;

    alu_decode_comb u_decode (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_5        (op_5),
        .funct7_5    (funct7_5),
        .alu_control (alu_control_next),
        .illegal     (illegal_next)
    );

    // Output register; reset parks the ALU on ADD with no fault flagged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_control <= ALU_ADD;
            illegal     <= 1'b0;
        end else begin
            alu_control <= alu_control_next;
            illegal     <= illegal_next;
        end
    end

endmodule

// File: tb/tb_riscv_alu_decoder.sv
// Directed-vector bench for riscv_alu_decoder with hand-computed expectations.
module tb_riscv_alu_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       op_5;
    logic       funct7_5;
    logic [2:0] alu_control;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    riscv_alu_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_5        (op_5),
        .funct7_5    (funct7_5),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got ctrl=%b ill=%b, expected ctrl=%b ill=%b",
                     tag, got[3:1], got[0], exp[3:1], exp[0]);
        end
    endtask

    // Drive inputs, let one rising edge sample them, check just after it
    task automatic step(input string tag, input logic [1:0] a, input logic [2:0] f3,
                        input logic o5, input logic f7, input logic [2:0] ec, input logic ei);
        alu_op   = a;
        funct3   = f3;
        op_5     = o5;
        funct7_5 = f7;
        @(posedge clk);
        #1;
        chk(tag, {alu_control, illegal}, {ec, ei});
    endtask

    typedef struct {
        logic [1:0] a;
        logic [2:0] f3;
        logic       o5;
        logic       f7;
        logic [2:0] ec;
        logic       ei;
    } vec_t;

    vec_t b2b[6];

    initial begin
        reset    = 1'b1;
        alu_op   = 2'b10;
        funct3   = 3'b000;
        op_5     = 1'b1;
        funct7_5 = 1'b1;
        #2;
        chk("reset_pre_edge", {alu_control, illegal}, 4'b000_0);
        @(posedge clk);
        #1;
        chk("reset_hold", {alu_control, illegal}, 4'b000_0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_sub", {alu_control, illegal}, 4'b001_0);

        step("aluop00_x", 2'b00, 3'bxxx, 1'bx, 1'bx, 3'b000, 1'b0);
        step("aluop01_x", 2'b01, 3'bxxx, 1'bx, 1'bx, 3'b001, 1'b0);

        step("f3_000_00", 2'b10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
        step("f3_000_01", 2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0);
        step("f3_000_10", 2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0);
        step("f3_000_11", 2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0);

        step("f3_slt", 2'b10, 3'b010, 1'bx, 1'bx, 3'b101, 1'b0);
        step("f3_or",  2'b10, 3'b110, 1'bx, 1'bx, 3'b011, 1'b0);
        step("f3_and", 2'b10, 3'b111, 1'bx, 1'bx, 3'b010, 1'b0);
        step("f3_xor", 2'b10, 3'b100, 1'bx, 1'bx, 3'b100, 1'b0);

        step("f3_sll",      2'b10, 3'b001, 1'b1, 1'b0, 3'b110, 1'b0);
        step("f3_sll_f7",   2'b10, 3'b001, 1'b0, 1'b1, 3'b110, 1'b1);
        step("f3_srl",      2'b10, 3'b101, 1'b0, 1'b0, 3'b111, 1'b0);
        step("f3_sra_ill",  2'b10, 3'b101, 1'b1, 1'b1, 3'b111, 1'b1);
        step("aluop11_ill", 2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1);
        step("f3_sltu_ill", 2'b10, 3'b011, 1'b0, 1'b0, 3'b101, 1'b1);

        // Back-to-back changes: before the edge the old value must still show
        b2b[0] = '{2'b10, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0};
        b2b[1] = '{2'b01, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0};
        b2b[2] = '{2'b10, 3'b111, 1'b1, 1'b0, 3'b010, 1'b0};
        b2b[3] = '{2'b11, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1};
        b2b[4] = '{2'b10, 3'b110, 1'b1, 1'b1, 3'b011, 1'b0};
        b2b[5] = '{2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
        for (int i = 0; i < 6; i++) begin
            logic [3:0] prev;
            prev     = (i == 0) ? 4'b101_1 : {b2b[i-1].ec, b2b[i-1].ei};
            alu_op   = b2b[i].a;
            funct3   = b2b[i].f3;
            op_5     = b2b[i].o5;
            funct7_5 = b2b[i].f7;
            #1;
            chk($sformatf("b2b_lag_%0d", i), {alu_control, illegal}, prev);
            @(posedge clk);
            #1;
            chk($sformatf("b2b_new_%0d", i), {alu_control, illegal}, {b2b[i].ec, b2b[i].ei});
        end

        // Mid-stream async reset while an illegal code is registered
        step("pre_midreset", 2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1);
        step("pre_midreset2", 2'b10, 3'b101, 1'b0, 1'b1, 3'b111, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_async", {alu_control, illegal}, 4'b000_0);
        @(posedge clk);
        #1;
        chk("midreset_hold", {alu_control, illegal}, 4'b000_0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_midreset", {alu_control, illegal}, 4'b111_1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
